// File: rtl/audio_i2s_transmitter_if.sv
// Sample path and I2S pins of the audio transmitter, bundled as one port.
// slave: the transmitter itself; master: the producer/DAC side that drives i_sample.
interface audio_i2s_transmitter_if;
    logic [8:0] i_sample;
    logic       o_sample_stb;
    logic       o_bclk;
    logic       o_lrclk;
    logic       o_sdata;

    modport slave (
        input  i_sample,
        output o_sample_stb,
        output o_bclk,
        output o_lrclk,
        output o_sdata
    );

    modport master (
        output i_sample,
        input  o_sample_stb,
        input  o_bclk,
        input  o_lrclk,
        input  o_sdata
    );
endinterface

// File: rtl/audio_i2s_transmitter.sv
// Mono 9-bit offset-binary sample to 16-bit I2S stream, captured once per frame.
// Define AUDIO_I2S_LJ_EN for left-justified framing instead of standard I2S.
module audio_i2s_transmitter #(
    parameter int CLOCK_FREQ  = 12_288_000,
    parameter int SAMPLE_RATE = 48_000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    audio_i2s_transmitter_if.slave bus
);

    localparam int HALF  = CLOCK_FREQ / (SAMPLE_RATE * 128);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    generate
        if (HALF < 1 || CLOCK_FREQ != SAMPLE_RATE * 128 * HALF) begin : g_bad_ratio
            $error("CLOCK_FREQ must be an integer multiple (>=1) of SAMPLE_RATE*128");
        end
    endgenerate

    // Offset-binary to two's complement, scaled to the top of a 16-bit word.
    function automatic logic signed [15:0] f_convert(input logic [8:0] s);
        return signed'({~s[8], s[7:0], 7'd0});
    endfunction

    function automatic logic f_slot_bit(input logic signed [15:0] w, input logic [5:0] bc);
        logic [4:0] p;
`ifdef AUDIO_I2S_LJ_EN
        p = bc[4:0];
`else
        p = 5'(bc - 6'd1);
`endif
        if (p[4]) return 1'b0;
        return w[~p[3:0]];
    endfunction

    logic [CNT_W-1:0]   r_cnt;
    logic               r_bclk;
    logic [5:0]         r_bit_cnt;
    logic               r_lrclk;
    logic               r_sdata;
    logic               r_stb;
    logic signed [15:0] r_word;

    logic               w_wrap;
    logic               w_fall;
    logic [5:0]         w_bit_nxt;

    assign w_wrap    = (r_cnt == CNT_W'(HALF - 1));
    assign w_fall    = w_wrap && r_bclk;
    assign w_bit_nxt = r_bit_cnt + 6'd1;

    // Everything except the divider advances only on the BCLK falling edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_bclk    <= 1'b0;
            r_bit_cnt <= 6'd0;
            r_lrclk   <= 1'b0;
            r_sdata   <= 1'b0;
            r_stb     <= 1'b0;
            r_word    <= '0;
        end else begin
            r_stb <= 1'b0;
            if (w_wrap) begin
                r_cnt  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrclk   <= w_bit_nxt[5];
                r_sdata   <= f_slot_bit(r_word, w_bit_nxt);
                // Slot 63 is padding in both framings, so swapping the word here never tears.
                if (w_bit_nxt == 6'd63) begin
                    r_word <= f_convert(bus.i_sample);
                    r_stb  <= 1'b1;
                end
            end
        end
    end

    assign bus.o_sample_stb = r_stb;
    assign bus.o_bclk       = r_bclk;
    assign bus.o_lrclk      = r_lrclk;
    assign bus.o_sdata      = r_sdata;

endmodule
